// File: rtl/trigger_capture_pkg.sv
// rtl/trigger_capture_pkg.sv - shared types and trigger bit positions for trigger_capture
package trigger_capture_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ARMED,
      CAPTURE,
      DRAIN
   } state_t;

   localparam int TRIG_CH1_RISE = 0;
   localparam int TRIG_CH1_FALL = 1;
   localparam int TRIG_CH2_RISE = 2;
   localparam int TRIG_CH2_FALL = 3;

   function automatic logic trig_hit(input logic [3:0] trig, input logic [3:0] mask);
      return (trig[TRIG_CH1_RISE] & mask[TRIG_CH1_RISE]) |
             (trig[TRIG_CH1_FALL] & mask[TRIG_CH1_FALL]) |
             (trig[TRIG_CH2_RISE] & mask[TRIG_CH2_RISE]) |
             (trig[TRIG_CH2_FALL] & mask[TRIG_CH2_FALL]);
   endfunction

endpackage

// File: rtl/trigger_capture_fifo.sv
// rtl/trigger_capture_fifo.sv - first-word-fall-through sample FIFO with a discard pop
// One slot is kept empty so occupancy fits in ADDR_W bits; usable capacity is DEPTH-1.
module capture_fifo #(
   parameter int ADDR_W = 10
) (
   input  logic              stream_clk,
   input  logic              resetn,
   input  logic              wr,
   input  logic [31:0]       din,
   input  logic              rd,
   input  logic              discard,
   output logic [31:0]       dout,
   output logic [ADDR_W-1:0] occupancy,
   output logic              full,
   output logic              empty
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign occupancy = wr_ptr - rd_ptr;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (occupancy == ADDR_W'(DEPTH - 1));
   assign dout      = mem[rd_ptr];

   // A pop in the same cycle frees the head slot, so a write into a full FIFO still lands.
   assign do_rd = (rd | discard) & ~empty;
   assign do_wr = wr & (~full | do_rd);

   always_ff @(posedge stream_clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge stream_clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - pre/post trigger packet capture into an AXIS-style sink
// Optional TRIGGER_CAPTURE_FORCE_TRIG_EN adds a force_trig input that forces the next ARMED beat to hit.
module trigger_capture
   import trigger_capture_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int POST_W = 16
) (
   input  logic              stream_clk,
   input  logic              resetn,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [31:0]       s_tdata,
   input  logic [3:0]        trig,
   input  logic [3:0]        trig_mask,
   input  logic              arm,
   input  logic [ADDR_W-1:0] pre_count,
   input  logic [POST_W-1:0] post_count,
`ifdef TRIGGER_CAPTURE_FORCE_TRIG_EN
   input  logic              force_trig,
`endif
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [31:0]       m_tdata,
   output logic              m_tlast,
   output logic              busy,
   output logic              triggered,
   output logic              overflow
);

   state_t            state;
   logic [ADDR_W-1:0] pre_q;
   logic [POST_W-1:0] post_q;
   logic [POST_W-1:0] post_rem;
   logic [3:0]        mask_q;
   logic              force_q;

   logic              accepted;
   logic              hit;
   logic              fifo_wr;
   logic              fifo_rd;
   logic              fifo_discard;
   logic [31:0]       fifo_dout;
   logic [ADDR_W-1:0] occupancy;
   logic              fifo_full;
   logic              fifo_empty;

   assign accepted = s_tvalid & s_tready;
   assign hit      = accepted & (trig_hit(trig, mask_q) | force_q);
   assign busy     = (state != IDLE);

   assign m_tvalid = ((state == CAPTURE) || (state == DRAIN)) & ~fifo_empty;
   assign m_tlast  = (state == DRAIN) && (occupancy == ADDR_W'(1));
   assign m_tdata  = m_tvalid ? fifo_dout : 32'h0;
   assign fifo_rd  = m_tvalid & m_tready;

   // With pre=0 the ARMED history is empty, so non-hit beats are neither written nor discarded.
   assign fifo_wr = accepted & ((state == FILL) || (state == CAPTURE) ||
                                ((state == ARMED) && (hit || (pre_q != '0))));
   assign fifo_discard = accepted & (state == ARMED) & ~hit & (pre_q != '0);

   capture_fifo #(.ADDR_W(ADDR_W)) u_fifo (
      .stream_clk (stream_clk),
      .resetn     (resetn),
      .wr         (fifo_wr),
      .din        (s_tdata),
      .rd         (fifo_rd),
      .discard    (fifo_discard),
      .dout       (fifo_dout),
      .occupancy  (occupancy),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

`ifdef TRIGGER_CAPTURE_FORCE_TRIG_EN
   always_ff @(posedge stream_clk) begin
      if (!resetn || (state == IDLE) || hit) force_q <= 1'b0;
      else if (force_trig && (state == ARMED)) force_q <= 1'b1;
   end
`else
   assign force_q = 1'b0;
`endif

   always_ff @(posedge stream_clk) begin
      if (!resetn) begin
         state     <= IDLE;
         s_tready  <= 1'b0;
         triggered <= 1'b0;
         overflow  <= 1'b0;
         pre_q     <= '0;
         post_q    <= '0;
         post_rem  <= '0;
         mask_q    <= '0;
      end else begin
         s_tready <= 1'b1;
         case (state)
            IDLE: begin
               if (arm) begin
                  overflow <= 1'b0;
                  pre_q    <= pre_count;
                  post_q   <= post_count;
                  mask_q   <= trig_mask;
                  state    <= (pre_count != '0) ? FILL : ARMED;
               end
            end
            FILL: begin
               if (accepted && ((occupancy + 1'b1) == pre_q)) state <= ARMED;
            end
            ARMED: begin
               if (hit) begin
                  triggered <= 1'b1;
                  post_rem  <= post_q - 1'b1;
                  state     <= (post_q == POST_W'(1)) ? DRAIN : CAPTURE;
               end
            end
            CAPTURE: begin
               if (accepted) begin
                  if (fifo_full && !fifo_rd) overflow <= 1'b1;
                  post_rem <= post_rem - 1'b1;
                  if (post_rem == POST_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_rd && m_tlast) begin
                  triggered <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_capture.sv
// tb/tb_trigger_capture.sv - self-checking bench for trigger_capture against a window model
module tb_trigger_capture;

   localparam int ADDR_W = 4;
   localparam int POST_W = 16;
   localparam int CAP    = (1 << ADDR_W) - 1;

   logic              stream_clk = 1'b0;
   logic              resetn     = 1'b0;
   logic              s_tvalid   = 1'b0;
   logic              s_tready;
   logic [31:0]       s_tdata    = '0;
   logic [3:0]        trig       = '0;
   logic [3:0]        trig_mask  = '0;
   logic              arm        = 1'b0;
   logic [ADDR_W-1:0] pre_count  = '0;
   logic [POST_W-1:0] post_count = 16'd1;
`ifdef TRIGGER_CAPTURE_FORCE_TRIG_EN
   logic              force_trig = 1'b0;
`endif
   logic              m_tvalid;
   logic              m_tready   = 1'b0;
   logic [31:0]       m_tdata;
   logic              m_tlast;
   logic              busy;
   logic              triggered;
   logic              overflow;

   int errors = 0;
   int checks = 0;

   logic [35:0] beats [$];
   logic [31:0] outd  [$];
   logic        outl  [$];
   logic        prev_hold = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   trigger_capture #(.ADDR_W(ADDR_W), .POST_W(POST_W)) dut (
      .stream_clk (stream_clk),
      .resetn     (resetn),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tdata    (s_tdata),
      .trig       (trig),
      .trig_mask  (trig_mask),
      .arm        (arm),
      .pre_count  (pre_count),
      .post_count (post_count),
`ifdef TRIGGER_CAPTURE_FORCE_TRIG_EN
      .force_trig (force_trig),
`endif
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .busy       (busy),
      .triggered  (triggered),
      .overflow   (overflow)
   );

   always #5 stream_clk = ~stream_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, then record what the coming rising edge will transfer.
   task automatic cyc(input logic sv, input logic [31:0] d, input logic [3:0] t, input logic rdy);
      @(negedge stream_clk);
      arm      = 1'b0;
      s_tvalid = sv;
      s_tdata  = d;
      trig     = t;
      m_tready = rdy;
      if (prev_hold) begin
         chk("hold_valid", 32'(m_tvalid), 32'd1);
         chk("hold_data", m_tdata, prev_data);
         chk("hold_last", 32'(m_tlast), 32'(prev_last));
      end
      if (sv && s_tready) beats.push_back({t, d});
      if (m_tvalid && m_tready) begin
         outd.push_back(m_tdata);
         outl.push_back(m_tlast);
      end
      prev_hold = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
   endtask

   task automatic do_arm(input int pre, input int post, input logic [3:0] mask);
      @(negedge stream_clk);
      arm        = 1'b1;
      s_tvalid   = 1'b0;
      m_tready   = 1'b0;
      pre_count  = ADDR_W'(pre);
      post_count = POST_W'(post);
      trig_mask  = mask;
      beats.delete();
      outd.delete();
      outl.delete();
   endtask

   // Packet = accepted beats [t-pre, t+post-1], t = first masked hit at or after index pre;
   // when the window exceeds FIFO capacity with the sink stalled, only the first CAP beats survive.
   task automatic run(input string name, input int pre, input int post, input logic [3:0] mask,
                      input logic [3:0] bg, input logic [3:0] hbits, input int hit1, input int hit2,
                      input bit gaps, input bit rnd_ready, input int hold, input bit rnd_trig,
                      input logic [31:0] start);
      logic [31:0] val;
      logic [31:0] exp [$];
      logic [3:0]  t;
      logic        sv;
      logic        rdy;
      bit          done;
      int          tix;
      int          n;
      do_arm(pre, post, mask);
      val  = start;
      done = 0;
      n    = 0;
      while (n < 600 && !done) begin
         sv = gaps ? ($urandom_range(3) != 0) : 1'b1;
         if (rnd_trig) t = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
         else t = (val == 32'(hit1) || val == 32'(hit2)) ? hbits : bg;
         rdy = (n < hold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(1)) : 1'b1);
         cyc(sv, val, t, rdy);
         if (sv && s_tready) val++;
         if (n > 2 && !busy) done = 1;
         n++;
      end
      chk({name, "_timeout"}, 32'(done), 32'd1);
      tix = -1;
      for (int i = pre; i < beats.size(); i++) begin
         if ((beats[i][35:32] & mask) != 4'h0) begin
            tix = i;
            break;
         end
      end
      if (tix < 0 || tix + post > beats.size()) begin
         chk({name, "_model_window"}, 32'(tix), 32'hffff_ffff);
      end else begin
         for (int i = tix - pre; i < tix + post; i++) exp.push_back(beats[i][31:0]);
         while (exp.size() > CAP) void'(exp.pop_back());
         chk({name, "_len"}, 32'(outd.size()), 32'(exp.size()));
         for (int i = 0; i < outd.size() && i < exp.size(); i++) begin
            chk({name, "_data"}, outd[i], exp[i]);
            chk({name, "_last"}, 32'(outl[i]), 32'(i == exp.size() - 1));
         end
         chk({name, "_overflow"}, 32'(overflow), 32'(pre + post > CAP));
      end
      chk({name, "_busy_end"}, 32'(busy), 32'd0);
      chk({name, "_trig_end"}, 32'(triggered), 32'd0);
   endtask

   initial begin
      int pre, post;
      logic [31:0] v;

      repeat (3) @(posedge stream_clk);
      @(negedge stream_clk);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tlast", 32'(m_tlast), 32'd0);
      chk("rst_m_tdata", m_tdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_triggered", 32'(triggered), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      resetn = 1'b1;
      @(negedge stream_clk);
      chk("rst_ready_up", 32'(s_tready), 32'd1);

      run("basic", 4, 4, 4'b0001, 4'h0, 4'b0001, 20, -1, 0, 0, 0, 0, 32'd0);
      run("single", 0, 1, 4'b0001, 4'h0, 4'b0001, 7, -1, 0, 0, 0, 0, 32'd0);
      run("masked", 3, 5, 4'b0100, 4'b0001, 4'b0100, 50, -1, 0, 0, 0, 0, 32'd30);
      run("fill_ign", 8, 4, 4'b0001, 4'h0, 4'b0001, 102, 115, 0, 0, 0, 0, 32'd100);
      run("ovf", 10, 20, 4'b0001, 4'h0, 4'b0001, 212, -1, 0, 0, 80, 0, 32'd200);

      for (int k = 0; k < 6; k++) begin
         pre  = $urandom_range(14);
         post = $urandom_range(CAP - pre, 1);
         run("rand", pre, post, 4'($urandom_range(15, 1)), 4'h0, 4'h0, -1, -1,
             1, 1, 0, 1, $urandom);
      end

      do_arm(4, 8, 4'b0001);
      v = 32'd500;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, v, (v == 32'd506) ? 4'b0001 : 4'h0, 1'b0);
         v++;
      end
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_triggered", 32'(triggered), 32'd1);
      chk("mid_valid", 32'(m_tvalid), 32'd1);
      resetn = 1'b0;
      @(negedge stream_clk);
      chk("mrst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_s_tready", 32'(s_tready), 32'd0);
      chk("mrst_triggered", 32'(triggered), 32'd0);
      resetn    = 1'b1;
      prev_hold = 1'b0;
      @(negedge stream_clk);
      run("rearm", 5, 6, 4'b1000, 4'h0, 4'b1000, 720, -1, 1, 1, 0, 0, 32'd700);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Consumer of the level-trigger stage. Takes its pass-through 32-bit sample stream and its four trigger flags (ch1_rising, ch1_falling, ch2_rising, ch2_falling).
- Keeps a rolling pre-trigger history in a FIFO. On the first unmasked trigger after arm, emits one packet of PRE+POST samples with tlast to the DMA/AXIS sink.
- Single clock domain. The ADC stream is never back-pressured.

Parameters:
- ADDR_W, 10, FIFO address width; depth DEPTH = 2^ADDR_W words of 32 bits.
- POST_W, 16, width of post_count.

Ports:
- stream_clk  in  1  stream clock
- resetn  in  1  synchronous, active-low reset
- s_tvalid  in  1  upstream sample valid
- s_tready  out  1  upstream ready
- s_tdata  in  32  upstream sample, {ch2, ch1}
- trig  in  4  {ch2_falling, ch2_rising, ch1_falling, ch1_rising}, qualified with the same beat as s_tdata
- trig_mask  in  4  1 = trigger source enabled
- arm  in  1  single-cycle arm request
- pre_count  in  ADDR_W  samples kept before the trigger beat; legal range 0..DEPTH-2
- post_count  in  POST_W  samples from the trigger beat onward, including it; legal range >=1
- m_tvalid  out  1  downstream valid
- m_tready  in  1  downstream ready
- m_tdata  out  32  packet sample
- m_tlast  out  1  last beat of packet
- busy  out  1  state != IDLE
- triggered  out  1  high from the trigger beat until the packet completes
- overflow  out  1  sticky: a capture beat was dropped

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, FIFO flushed.
  - s_tready=0; all outputs 0, overflow cleared.
  - s_tready goes 1 on the first edge with resetn=1 and stays 1 thereafter.
  - Reset mid-packet abandons the packet; m_tvalid=0 from the next cycle.
- Accepted beat: s_tvalid & s_tready. Trigger flags are evaluated only on accepted beats. hit = |(trig & trig_mask).
- pre_count, post_count and trig_mask are sampled into internal registers when arm is accepted.
- IDLE:
  - Beats are discarded.
  - arm=1 -> clear overflow, load the counts; go to FILL if pre>0, else to ARMED.
  - arm is ignored in every other state.
- FILL:
  - Each accepted beat is written to the FIFO; triggers are ignored.
  - Go to ARMED when occupancy reaches pre, on the cycle that write lands.
- ARMED, accepted beat without hit:
  - Beat is written.
  - The FIFO head is popped and discarded in the same cycle, so occupancy holds at pre.
  - If pre=0, the beat is not written.
- ARMED, accepted beat with hit:
  - Beat is written with no discard.
  - triggered=1; post_remaining=post-1.
  - Go to CAPTURE; go directly to DRAIN if post=1.
- CAPTURE:
  - Each accepted beat is written and decrements post_remaining.
  - The beat that brings post_remaining to 0 -> DRAIN.
  - A write while the FIFO is full drops that beat, sets overflow, and still decrements post_remaining.
- DRAIN:
  - No writes; incoming beats are discarded.
  - m_tlast=1 when occupancy==1.
  - Handshake on the tlast beat -> IDLE, triggered=0.
- Output side:
  - FIFO is first-word-fall-through; m_tvalid = FIFO not empty, in CAPTURE or DRAIN only.
  - m_tvalid asserts at most 2 cycles after the trigger beat.
  - m_tdata/m_tlast hold stable while m_tvalid & !m_tready.
  - In ARMED, FIFO pops happen only through the discard path and are never visible on m_.
- Simultaneous write and read on a full FIFO in CAPTURE: the read frees a slot and the write succeeds; overflow is not set.
- Packet length: pre+post beats, minus any dropped beats. Sample index pre is the trigger beat.

Optional Feature:
- Macro: TRIGGER_CAPTURE_FORCE_TRIG_EN.
- With the macro defined:
  - Adds input force_trig (1 bit).
  - A force_trig pulse in ARMED is latched, and the next accepted beat is treated as hit regardless of trig_mask.
  - The latch clears on trigger, on reset, and on return to IDLE.
- Without the macro: the port is absent and only masked trig bits cause a hit.

Decomposition:
- Package trigger_capture_pkg holds:
  - State enum: IDLE, FILL, ARMED, CAPTURE, DRAIN.
  - Trigger bit index constants: TRIG_CH1_RISE=0, TRIG_CH1_FALL=1, TRIG_CH2_RISE=2, TRIG_CH2_FALL=3.
- Sub-module capture_fifo: synchronous FWFT FIFO, parameter ADDR_W.
  - Ports: wr, rd, discard (pop without output), dout, occupancy, full, empty.
  - The controller FSM lives in trigger_capture.

Test Plan:
- Arm with pre=4, post=4, mask=0001; ramp data 0,1,2,...; trig[0] on the beat with value 20 -> packet 16..23, tlast on 23, overflow=0.
- Arm with pre=0, post=1; hit on value 7 -> single beat 7 with m_tlast=1, then busy=0.
- Arm with mask=0100 and drive trig=0001 continuously -> no packet. Then trig[2] on value 50 -> packet whose index pre holds 50.
- Trigger during FILL (pre=8, hit on the 3rd beat) -> ignored; the first hit after ARMED is used.
- Depth 16, pre=10, post=20, m_tready held 0 -> overflow=1. Release m_tready -> packet of 15 beats (16 minus the held slot, per occupancy), tlast on the final beat.
- Drop resetn mid-CAPTURE -> next cycle m_tvalid=0, busy=0, s_tready=0. Re-arm after reset -> clean packet.
